dcsk_demod: RTL and testbench

DCSK_DEMOD -- requirements
Module: dcsk_demod

---
 rtl/dcsk_pkg.sv | 24 ++
 rtl/ref_chip_buf.sv | 34 +++
 rtl/dcsk_demod.sv | 162 ++++++++++++++++
 tb/tb_dcsk_demod.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcsk_pkg
//  Brief    : Shared constants and FSM state type for the DCSK modem pair.
//  Revision : 1.0 - initial release
// ============================================================================
package dcsk_pkg;

  // Message bits per frame, shared with the modulator
  localparam int MSG_W  = 32;
  // Largest spreading factor, in chips per half-symbol
  localparam int MAX_SF = 64;
  // Width of the spreading-factor field; 2**SF_W must exceed MAX_SF
  localparam int SF_W   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ref_chip_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ref_chip_buf
//  Brief    : Reference-chip store; 1-bit entries, synchronous write,
//             combinational read.
//  Revision : 1.0 - initial release
// ============================================================================
module ref_chip_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic          o_rdata
);

  // Contents are deliberately not reset: every entry read in a symbol has
  // been written earlier in the same symbol.
  logic r_mem [DEPTH];

  // Store one reference chip per accepted write
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dcsk_demod.sv
`default_nettype none
// ============================================================================
//  Module   : dcsk_demod
//  Brief    : Serial DCSK demodulator. Stores the reference half-symbol,
//             correlates the data half-symbol against it by majority vote
//             and assembles MSG_W decided bits MSB first.
//  Revision : 1.0 - initial release
// ============================================================================
module dcsk_demod #(
  parameter int MSG_W  = dcsk_pkg::MSG_W,
  parameter int MAX_SF = dcsk_pkg::MAX_SF,
  parameter int SF_W   = dcsk_pkg::SF_W
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_start,
  input  logic [SF_W-1:0]  i_sf,
  input  logic             i_chip,
  input  logic             i_chip_valid,
  output logic             o_busy,
  output logic [MSG_W-1:0] o_msg,
  output logic             o_msg_valid,
  output logic             o_sf_err
);

  import dcsk_pkg::*;

  localparam int                c_BUF_AW   = (MAX_SF > 1) ? $clog2(MAX_SF) : 1;
  localparam int                c_BC_W     = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [c_BC_W-1:0] c_LAST_BIT = c_BC_W'(MSG_W - 1);
  localparam logic [SF_W-1:0]   c_MAX_SF   = SF_W'(MAX_SF);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SF_W-1:0]    r_sf;
  logic [SF_W-1:0]    r_idx;
  logic [SF_W:0]      r_agree;
  logic [c_BC_W-1:0]  r_bit_cnt;
  logic [MSG_W-1:0]   r_shift;
  logic [MSG_W-1:0]   r_msg;
  logic               r_msg_valid;
  logic               r_sf_err;

  logic               w_sf_ok;
  logic               w_idx_last;
  logic               w_ref_chip;
  logic [SF_W:0]      w_agree_tot;
  logic               w_bit;
  logic               w_buf_we;
  logic [c_BUF_AW-1:0] w_buf_addr;

  // Requested spreading factor is usable only in the range 1..MAX_SF
  assign w_sf_ok     = (i_sf != '0) && (i_sf <= c_MAX_SF);
  assign w_idx_last  = (r_idx == (r_sf - SF_W'(1)));
  // Running agreement including the chip on the input this cycle
  assign w_agree_tot = r_agree + {{SF_W{1'b0}}, (i_chip == w_ref_chip)};
  // Strict majority decides 1; an exact tie falls to 0
  assign w_bit       = ({w_agree_tot, 1'b0} > {2'b00, r_sf});
  assign w_buf_addr  = r_idx[c_BUF_AW-1:0];

  ref_chip_buf #(
    .DEPTH (MAX_SF),
    .AW    (c_BUF_AW)
  ) u_ref_buf (
    .i_clk   (i_clk),
    .i_we    (w_buf_we),
    .i_waddr (w_buf_addr),
    .i_wdata (i_chip),
    .i_raddr (w_buf_addr),
    .o_rdata (w_ref_chip)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; idle-valid cycles hold the current state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = REF;
      REF:  if (i_chip_valid && w_idx_last) w_state_nxt = DATA;
      DATA: begin
        if (i_chip_valid && w_idx_last) begin
          w_state_nxt = (r_bit_cnt == c_LAST_BIT) ? DONE : REF;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    o_busy   = (r_state != IDLE);
    w_buf_we = (r_state == REF) && i_chip_valid;
  end

  // Counters, decision shift register and published message
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sf        <= '0;
      r_idx       <= '0;
      r_agree     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_msg       <= '0;
      r_msg_valid <= 1'b0;
      r_sf_err    <= 1'b0;
    end else begin
      r_msg_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_sf      <= w_sf_ok ? i_sf : c_MAX_SF;
            r_idx     <= '0;
            r_agree   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            if (!w_sf_ok) begin
              r_sf_err <= 1'b1;
            end
          end
        end
        REF: begin
          if (i_chip_valid) begin
            r_idx <= w_idx_last ? '0 : r_idx + SF_W'(1);
          end
        end
        DATA: begin
          if (i_chip_valid) begin
            if (w_idx_last) begin
              r_shift   <= {r_shift[MSG_W-2:0], w_bit};
              r_agree   <= '0;
              r_idx     <= '0;
              r_bit_cnt <= r_bit_cnt + c_BC_W'(1);
            end else begin
              r_agree <= w_agree_tot;
              r_idx   <= r_idx + SF_W'(1);
            end
          end
        end
        DONE: begin
          r_msg       <= r_shift;
          r_msg_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_msg       = r_msg;
  assign o_msg_valid = r_msg_valid;
  assign o_sf_err    = r_sf_err;

endmodule
`default_nettype wire

// File: tb/tb_dcsk_demod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcsk_demod
//  Brief    : Self-checking bench for dcsk_demod with a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcsk_demod;

  import dcsk_pkg::*;

  logic             i_clk        = 1'b0;
  logic             i_arst_n     = 1'b1;
  logic             i_start      = 1'b0;
  logic [SF_W-1:0]  i_sf         = '0;
  logic             i_chip       = 1'b0;
  logic             i_chip_valid = 1'b0;
  logic             o_busy;
  logic [MSG_W-1:0] o_msg;
  logic             o_msg_valid;
  logic             o_sf_err;

  dcsk_demod #(
    .MSG_W  (MSG_W),
    .MAX_SF (MAX_SF),
    .SF_W   (SF_W)
  ) dut (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_start      (i_start),
    .i_sf         (i_sf),
    .i_chip       (i_chip),
    .i_chip_valid (i_chip_valid),
    .o_busy       (o_busy),
    .o_msg        (o_msg),
    .o_msg_valid  (o_msg_valid),
    .o_sf_err     (o_sf_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc            = 0;
  int n_valid        = 0;
  int last_valid_cyc = 0;
  int n_cmp          = 0;
  int n_err          = 0;
  int busy_lows      = 0;

  // Free-running cycle counter
  always @(posedge i_clk) cyc <= cyc + 1;

  // Count message-valid pulses, sampled away from the active edge
  always @(negedge i_clk) begin
    if (o_msg_valid === 1'b1) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one chip after an optional number of idle (invalid) cycles
  task automatic send_chip(input logic c, input int gap);
    repeat (gap) begin
      @(negedge i_clk);
      i_start      = 1'b0;
      i_chip_valid = 1'b0;
      i_chip       = 1'($urandom);
      if (o_busy !== 1'b1) busy_lows++;
    end
    @(negedge i_clk);
    i_start      = 1'b0;
    i_chip       = c;
    i_chip_valid = 1'b1;
    if (o_busy !== 1'b1) busy_lows++;
  endtask

  task automatic start_pulse();
    @(negedge i_clk);
    i_start      = 1'b1;
    i_sf         = SF_W'(1);
    i_chip_valid = 1'b0;
  endtask

  // Transmit a frame and predict the decoded word from the chips actually sent
  task automatic run_frame(input logic [SF_W-1:0] sf_in, input logic [31:0] msg,
                           input int gap, input int flips0, input bit rflip,
                           input int pulse_at, input int abort_at,
                           output logic [31:0] expm, output int t0);
    int   sf_eff;
    int   agree;
    int   chip_no;
    logic rc [MAX_SF];
    logic d;
    logic f;
    sf_eff  = (sf_in == '0 || int'(sf_in) > MAX_SF) ? MAX_SF : int'(sf_in);
    expm    = '0;
    chip_no = 0;
    busy_lows = 0;
    @(negedge i_clk);
    i_start      = 1'b1;
    i_sf         = sf_in;
    i_chip_valid = 1'b0;
    @(posedge i_clk);
    #1;
    t0 = cyc;
    for (int b = MSG_W - 1; b >= 0; b--) begin
      for (int k = 0; k < sf_eff; k++) begin
        rc[k] = 1'($urandom);
        if (chip_no == abort_at) return;
        if (chip_no == pulse_at) start_pulse();
        send_chip(rc[k], gap);
        chip_no++;
      end
      agree = 0;
      for (int k = 0; k < sf_eff; k++) begin
        f = ((b == MSG_W - 1) && (k < flips0)) || (rflip && ($urandom_range(0, 3) == 0));
        d = (msg[b] ? rc[k] : ~rc[k]) ^ f;
        if (d == rc[k]) agree++;
        if (chip_no == abort_at) return;
        if (chip_no == pulse_at) start_pulse();
        send_chip(d, gap);
        chip_no++;
      end
      expm[b] = (2 * agree > sf_eff);
    end
    @(negedge i_clk);
    i_chip_valid = 1'b0;
  endtask

  // Wait (bounded) for the message pulse, then check result and pulse count
  task automatic await_msg(input int nv0, input logic [31:0] expm, input string tag);
    int waited;
    waited = 0;
    while (n_valid == nv0 && waited < 40) begin
      @(negedge i_clk);
      #1;
      waited++;
    end
    check({tag, "_valid_seen"}, 32'(n_valid != nv0), 32'd1);
    check({tag, "_msg"}, o_msg, expm);
    repeat (4) @(negedge i_clk);
    #1;
    check({tag, "_pulses"}, 32'(n_valid - nv0), 32'd1);
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
  endtask

  logic [31:0] expm;
  logic [31:0] rmsg;
  int          t0;
  int          nv0;

  initial begin
    // Asynchronous reset with no clock edge needed
    #1 i_arst_n = 1'b0;
    #2;
    check("rst_busy",   32'(o_busy),      32'd0);
    check("rst_msg",    o_msg,            32'd0);
    check("rst_valid",  32'(o_msg_valid), 32'd0);
    check("rst_sf_err", 32'(o_sf_err),    32'd0);
    #20;
    @(negedge i_clk);
    i_arst_n = 1'b1;

    // sf=4, back-to-back, latency from start
    nv0 = n_valid;
    run_frame(SF_W'(4), 32'hA5A5_5A5A, 0, 0, 1'b0, -1, -1, expm, t0);
    await_msg(nv0, expm, "s1");
    check("s1_const",   o_msg, 32'hA5A5_5A5A);
    check("s1_latency", 32'(last_valid_cyc - t0), 32'd257);
    check("s1_sf_err",  32'(o_sf_err), 32'd0);
    repeat (5) @(negedge i_clk);
    check("s1_hold",    o_msg, 32'hA5A5_5A5A);

    // sf=8, one chip every 3rd cycle, busy must never drop
    nv0 = n_valid;
    run_frame(SF_W'(8), 32'hFFFF_0000, 2, 0, 1'b0, -1, -1, expm, t0);
    check("s2_busy_lows", 32'(busy_lows), 32'd0);
    await_msg(nv0, expm, "s2");
    check("s2_const", o_msg, 32'hFFFF_0000);

    // Tie: 2 of 4 chips flipped on a '1' symbol decides 0
    nv0 = n_valid;
    run_frame(SF_W'(4), 32'hC3C3_C3C3, 0, 2, 1'b0, -1, -1, expm, t0);
    await_msg(nv0, expm, "s3tie");
    check("s3tie_bit31", 32'(o_msg[31]), 32'd0);

    // One of 4 flipped still decides 1
    nv0 = n_valid;
    run_frame(SF_W'(4), 32'hC3C3_C3C3, 0, 1, 1'b0, -1, -1, expm, t0);
    await_msg(nv0, expm, "s3one");
    check("s3one_bit31", 32'(o_msg[31]), 32'd1);

    // Illegal sf=0 falls back to MAX_SF and raises the sticky error
    nv0 = n_valid;
    run_frame(SF_W'(0), 32'h1234_5678, 0, 0, 1'b0, -1, -1, expm, t0);
    check("s4_sf_err", 32'(o_sf_err), 32'd1);
    await_msg(nv0, expm, "s4");
    check("s4_const", o_msg, 32'h1234_5678);

    // Start pulse mid-frame must not disturb the frame
    nv0 = n_valid;
    run_frame(SF_W'(3), 32'h5A5A_00FF, 0, 0, 1'b0, 20, -1, expm, t0);
    await_msg(nv0, expm, "s5pulse");
    check("s5pulse_const", o_msg, 32'h5A5A_00FF);

    // Reset mid-frame abandons it immediately
    nv0 = n_valid;
    run_frame(SF_W'(2), 32'($urandom), 0, 0, 1'b0, -1, 40, expm, t0);
    @(posedge i_clk);
    #2;
    i_arst_n     = 1'b0;
    i_chip_valid = 1'b0;
    #1;
    check("s5rst_busy",   32'(o_busy),   32'd0);
    check("s5rst_msg",    o_msg,         32'd0);
    check("s5rst_sf_err", 32'(o_sf_err), 32'd0);
    repeat (3) @(negedge i_clk);
    i_arst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    #1;
    check("s5rst_no_valid", 32'(n_valid - nv0), 32'd0);

    // sf=1 frame after the reset
    nv0 = n_valid;
    run_frame(SF_W'(1), 32'h0000_0001, 0, 0, 1'b0, -1, -1, expm, t0);
    await_msg(nv0, expm, "s6");
    check("s6_const", o_msg, 32'h0000_0001);

    // Randomized frames with noise and gaps
    for (int n = 0; n < 4; n++) begin
      nv0  = n_valid;
      rmsg = 32'($urandom);
      run_frame(SF_W'($urandom_range(1, 20)), rmsg, int'($urandom_range(0, 2)),
                0, 1'b1, -1, -1, expm, t0);
      await_msg(nv0, expm, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
